// File: rtl/simpson_pkg.sv
// Shared types and constants for the Simpson's-rule integrator controller.
package simpson_pkg;

   typedef enum logic [2:0] {IDLE, EVAL, SCALE, DIV, DONE} state_t;

   localparam int SIMPSON_DIVISOR = 48;
   localparam int HORNER_STEPS    = 3;
   localparam int NUM_POINTS      = 3;
   localparam int DIV_REM_W       = $clog2(SIMPSON_DIVISOR);

   localparam int unsigned POINT_WEIGHT [NUM_POINTS] = '{1, 4, 1};

   // Weights are powers of two, so accumulation uses a shift instead of a second multiplier.
   function automatic logic [1:0] weight_shift(input logic [1:0] pt);
      weight_shift = '0;
      for (int i = 0; i < NUM_POINTS; i++)
         if (pt == i[1:0]) weight_shift = 2'($clog2(POINT_WEIGHT[i]));
   endfunction

endpackage

// File: rtl/simpson_if.sv
// Operand/start request and result/status bundle between front end and controller.
interface simpson_if #(parameter int DW = 8, parameter int RW = 16);

   logic          start;
   logic [DW-1:0] a0, a1, a2, a3, a, b;
   logic          busy;
   logic          done;
   logic [RW-1:0] result;
   logic          error;
   logic          ovf;

   modport master (output start, a0, a1, a2, a3, a, b,
                   input  busy, done, result, error, ovf);

   modport slave  (input  start, a0, a1, a2, a3, a, b,
                   output busy, done, result, error, ovf);

endinterface

// File: rtl/simpson_div.sv
// Restoring divider by SIMPSON_DIVISOR, one quotient bit per cycle MSB first.
// Latency IW cycles: the go cycle produces the first bit; ready_o rises after the last.
module simpson_div
   import simpson_pkg::*;
#(
   parameter int IW = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go_i,
   input  logic [IW-1:0]        dividend_i,
   output logic [IW-1:0]        quotient_o,
   output logic [DIV_REM_W-1:0] remainder_o,
   output logic                 ready_o
);

   localparam int CW = $clog2(IW + 1);
   localparam logic [DIV_REM_W:0] DIVISOR = (DIV_REM_W + 1)'(SIMPSON_DIVISOR);

   logic [IW-1:0]        quo_q, quo_d, src;
   logic [DIV_REM_W-1:0] rem_q, rem_d, rsrc;
   logic [CW-1:0]        cnt_q;
   logic [DIV_REM_W:0]   trial, diff;
   logic                 qbit;

   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   always_comb begin
      src   = go_i ? dividend_i : quo_q;
      rsrc  = go_i ? '0 : rem_q;
      trial = {rsrc, src[IW-1]};
      diff  = trial - DIVISOR;
      qbit  = (trial >= DIVISOR);
      rem_d = qbit ? diff[DIV_REM_W-1:0] : trial[DIV_REM_W-1:0];
      quo_d = {src[IW-2:0], qbit};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
      end else if (go_i) begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         cnt_q <= CW'(IW - 1);
      end else if (cnt_q != '0) begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign ready_o     = (cnt_q == '0);

endmodule

// File: rtl/simpson_ctrl.sv
// Simpson's-rule integrator sequencer: one shared multiplier for Horner evaluation and scaling, then divide by 48.
// Latency 59 cycles (IW=48) from accept to done, 1 cycle on bad bounds; start while busy is dropped.
module simpson_ctrl
   import simpson_pkg::*;
#(
   parameter int DW = 8,
   parameter int IW = 48,
   parameter int RW = 16
) (
   input  logic     clk,
   input  logic     rst,
   simpson_if.slave ctrl_if
);

   state_t               state_q;
   logic [DW-1:0]        a0_q, a1_q, a2_q, a3_q, lo_q, hi_q;
   logic [IW-1:0]        acc_q, s_q;
   logic [1:0]           pt_q, hs_q;
   logic                 err_q, busy_q, done_q, error_q, ovf_q;
   logic [RW-1:0]        result_q;

   logic [IW-1:0]        y, mul_a, mul_b, mul_p, addend, horner_d, s_d;
   logic [IW-1:0]        quo;
   logic [DIV_REM_W-1:0] div_rem;
   logic                 div_go, div_rdy, quo_ovf;

   // Evaluation points are doubled (2a, a+b, 2b) so the midpoint stays integral.
   always_comb begin
      case (pt_q)
         2'd0:    y = IW'({lo_q, 1'b0});
         2'd1:    y = IW'(lo_q) + IW'(hi_q);
         default: y = IW'({hi_q, 1'b0});
      endcase
      case (hs_q)
         2'd0:    addend = IW'(a2_q) << 1;
         2'd1:    addend = IW'(a1_q) << 2;
         default: addend = IW'(a0_q) << 3;
      endcase
      if (state_q == SCALE) begin
         mul_a = s_q;
         mul_b = IW'(hi_q - lo_q);
      end else begin
         mul_a = (hs_q == 2'd0) ? IW'(a3_q) : acc_q;
         mul_b = y;
      end
   end

   assign mul_p    = mul_a * mul_b;
   assign horner_d = mul_p + addend;
   assign s_d      = s_q + (horner_d << weight_shift(pt_q));
   assign div_go   = (state_q == SCALE);
   assign quo_ovf  = |quo[IW-1:RW];

   simpson_div #(.IW(IW)) u_div (
      .clk         (clk),
      .rst         (rst),
      .go_i        (div_go),
      .dividend_i  (mul_p),
      .quotient_o  (quo),
      .remainder_o (div_rem),
      .ready_o     (div_rdy)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         {a0_q, a1_q, a2_q, a3_q, lo_q, hi_q} <= '0;
         acc_q    <= '0;
         s_q      <= '0;
         pt_q     <= '0;
         hs_q     <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (ctrl_if.start) begin
               a0_q    <= ctrl_if.a0;
               a1_q    <= ctrl_if.a1;
               a2_q    <= ctrl_if.a2;
               a3_q    <= ctrl_if.a3;
               lo_q    <= ctrl_if.a;
               hi_q    <= ctrl_if.b;
               s_q     <= '0;
               pt_q    <= '0;
               hs_q    <= '0;
               busy_q  <= 1'b1;
               err_q   <= (ctrl_if.a > ctrl_if.b);
               state_q <= (ctrl_if.a > ctrl_if.b) ? DONE : EVAL;
            end
            EVAL: begin
               acc_q <= horner_d;
               if (hs_q == 2'(HORNER_STEPS - 1)) begin
                  s_q  <= s_d;
                  hs_q <= '0;
                  pt_q <= pt_q + 2'd1;
                  if (pt_q == 2'(NUM_POINTS - 1)) state_q <= SCALE;
               end else begin
                  hs_q <= hs_q + 2'd1;
               end
            end
            SCALE: state_q <= DIV;
            DIV:   if (div_rdy) state_q <= DONE;
            DONE: begin
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               error_q  <= err_q;
               ovf_q    <= !err_q && quo_ovf;
               result_q <= err_q ? '0 : (quo_ovf ? '1 : quo[RW-1:0]);
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      if (state_q == DONE && !err_q)
         assert (div_rem < DIV_REM_W'(SIMPSON_DIVISOR));
   end

   assign ctrl_if.busy   = busy_q;
   assign ctrl_if.done   = done_q;
   assign ctrl_if.result = result_q;
   assign ctrl_if.error  = error_q;
   assign ctrl_if.ovf    = ovf_q;

endmodule

// File: tb/tb_simpson_ctrl.sv
// Self-checking bench for simpson_ctrl against an antiderivative-based integral model.
module tb_simpson_ctrl;

   localparam int DW = 8;
   localparam int IW = 48;
   localparam int RW = 16;
   localparam int LAT = 59;

   typedef struct packed {
      logic [7:0] c0, c1, c2, c3, lo, hi;
   } op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   simpson_if #(.DW(DW), .RW(RW)) bus ();

   simpson_ctrl #(.DW(DW), .IW(IW), .RW(RW)) dut (
      .clk     (clk),
      .rst     (rst),
      .ctrl_if (bus)
   );

   always #5 clk = ~clk;

   // 12 * integral = 12a0(B-A) + 6a1(B^2-A^2) + 4a2(B^3-A^3) + 3a3(B^4-A^4)
   function automatic void model(input op_t op, output logic [15:0] r, output logic o, output logic e);
      longint unsigned A, B, i12, q;
      A = longint'(op.lo);
      B = longint'(op.hi);
      r = '0; o = 1'b0; e = 1'b0;
      if (op.lo > op.hi) begin
         e = 1'b1;
      end else begin
         i12 = 12 * longint'(op.c0) * (B - A)
             + 6  * longint'(op.c1) * (B*B - A*A)
             + 4  * longint'(op.c2) * (B*B*B - A*A*A)
             + 3  * longint'(op.c3) * (B*B*B*B - A*A*A*A);
         q = i12 / 12;
         if (q >= 64'd65536) begin
            r = 16'hFFFF;
            o = 1'b1;
         end else begin
            r = q[15:0];
         end
      end
   endfunction

   function automatic op_t rand_op();
      op_t op;
      logic [7:0] t;
      op.c0 = 8'($urandom); op.c1 = 8'($urandom);
      op.c2 = 8'($urandom); op.c3 = 8'($urandom);
      op.lo = 8'($urandom); op.hi = 8'($urandom);
      if (op.lo > op.hi && $urandom_range(0, 3) != 0) begin
         t = op.lo; op.lo = op.hi; op.hi = t;
      end
      if ($urandom_range(0, 6) == 0) op.hi = op.lo;
      if ($urandom_range(0, 3) == 0) op.hi = 8'($urandom_range(0, 20)) + op.lo / 8'd16;
      return op;
   endfunction

   task automatic drive(input op_t op);
      bus.a0 = op.c0; bus.a1 = op.c1; bus.a2 = op.c2; bus.a3 = op.c3;
      bus.a  = op.lo; bus.b  = op.hi;
   endtask

   // Returns #1 after the accepting edge, with operands scrambled to prove they were latched.
   task automatic issue(input op_t op, input bit immediate);
      if (!immediate) @(negedge clk);
      drive(op);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      drive(rand_op());
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done === 1'b1) return;
      end
      $display("FAIL wait_done: no done within %0d cycles", lat);
      n_cmp++; n_bad++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      drive('0);
      repeat (3) @(posedge clk);
      #1;
      if ({bus.busy, bus.done, bus.result, bus.error, bus.ovf} !== 20'd0) begin
         $display("FAIL reset_state: got busy=%b done=%b r=%0d err=%b ovf=%b, want all 0",
                  bus.busy, bus.done, bus.result, bus.error, bus.ovf);
         n_bad++;
      end
      n_cmp++;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_plan_vectors();
      op_t         ops [3];
      logic [15:0] want [3];
      int          lat;
      ops[0] = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd7, 8'd16}; want[0] = 16'd63;
      ops[1] = '{8'd1, 8'd3, 8'd0, 8'd0, 8'd2, 8'd8};  want[1] = 16'd96;
      ops[2] = '{8'd4, 8'd2, 8'd1, 8'd0, 8'd1, 8'd6};  want[2] = 16'd126;
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], 1'b0);
         if (bus.busy !== 1'b1) begin
            $display("FAIL plan%0d busy: got %b want 1", i, bus.busy); n_bad++;
         end
         n_cmp++;
         wait_done(lat);
         if (lat !== LAT) begin
            $display("FAIL plan%0d latency: got %0d want %0d", i, lat, LAT); n_bad++;
         end
         n_cmp++;
         if ({bus.result, bus.ovf, bus.error, bus.busy} !== {want[i], 3'b000}) begin
            $display("FAIL plan%0d result: got r=%0d ovf=%b err=%b busy=%b, want r=%0d ovf=0 err=0 busy=0",
                     i, bus.result, bus.ovf, bus.error, bus.busy, want[i]); n_bad++;
         end
         n_cmp++;
         repeat (3) @(posedge clk);
         #1;
         if ({bus.done, bus.result} !== {1'b0, want[i]}) begin
            $display("FAIL plan%0d hold: got done=%b r=%0d, want done=0 r=%0d",
                     i, bus.done, bus.result, want[i]); n_bad++;
         end
         n_cmp++;
      end
   endtask

   task automatic test_back_to_back();
      op_t         ops [2];
      logic [15:0] want [2];
      int          lat;
      ops[0] = '{8'd1, 8'd1, 8'd2, 8'd1, 8'd2, 8'd5};  want[0] = 16'd243;
      ops[1] = '{8'd4, 8'd10, 8'd0, 8'd2, 8'd5, 8'd12}; want[1] = 16'd10678;
      issue(ops[0], 1'b0);
      for (int i = 0; i < 2; i++) begin
         wait_done(lat);
         if (i == 0) issue(ops[1], 1'b1);
         if (lat !== LAT) begin
            $display("FAIL b2b%0d latency: got %0d want %0d", i, lat, LAT); n_bad++;
         end
         n_cmp++;
         if (bus.result !== want[i]) begin
            $display("FAIL b2b%0d result: got %0d want %0d", i, bus.result, want[i]); n_bad++;
         end
         n_cmp++;
      end
   endtask

   task automatic test_error_and_equal();
      int lat;
      issue('{8'd1, 8'd1, 8'd1, 8'd1, 8'd5, 8'd4}, 1'b0);
      wait_done(lat);
      if ({lat, bus.result, bus.error, bus.ovf} !== {32'd1, 16'd0, 1'b1, 1'b0}) begin
         $display("FAIL error_path: got lat=%0d r=%0d err=%b ovf=%b, want lat=1 r=0 err=1 ovf=0",
                  lat, bus.result, bus.error, bus.ovf); n_bad++;
      end
      n_cmp++;
      issue('{8'd1, 8'd1, 8'd1, 8'd1, 8'd9, 8'd9}, 1'b0);
      wait_done(lat);
      if ({lat, bus.result, bus.error, bus.ovf} !== {32'(LAT), 16'd0, 1'b0, 1'b0}) begin
         $display("FAIL equal_bounds: got lat=%0d r=%0d err=%b ovf=%b, want lat=%0d r=0 err=0 ovf=0",
                  lat, bus.result, bus.error, bus.ovf, LAT); n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_overflow();
      int lat;
      issue('{8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255}, 1'b0);
      wait_done(lat);
      if ({bus.result, bus.ovf, bus.error} !== {16'hFFFF, 1'b1, 1'b0}) begin
         $display("FAIL overflow: got r=%h ovf=%b err=%b, want r=ffff ovf=1 err=0",
                  bus.result, bus.ovf, bus.error); n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_random();
      op_t         op;
      logic [15:0] er;
      logic        eo, ee;
      int          lat;
      for (int i = 0; i < 30; i++) begin
         op = rand_op();
         model(op, er, eo, ee);
         issue(op, $urandom_range(0, 1) == 1);
         wait_done(lat);
         if (lat !== (ee ? 1 : LAT)) begin
            $display("FAIL rand%0d latency: got %0d want %0d", i, lat, ee ? 1 : LAT); n_bad++;
         end
         n_cmp++;
         if ({bus.result, bus.ovf, bus.error} !== {er, eo, ee}) begin
            $display("FAIL rand%0d outputs: got r=%0d ovf=%b err=%b, want r=%0d ovf=%b err=%b (op %h)",
                     i, bus.result, bus.ovf, bus.error, er, eo, ee, op); n_bad++;
         end
         n_cmp++;
      end
   endtask

   task automatic test_ignored_start();
      op_t         op;
      logic [15:0] er;
      logic        eo, ee;
      int          lat;
      op = '{8'd3, 8'd5, 8'd2, 8'd1, 8'd3, 8'd11};
      model(op, er, eo, ee);
      issue(op, 1'b0);
      repeat (19) @(posedge clk);
      #1;
      drive('{8'd200, 8'd200, 8'd200, 8'd200, 8'd0, 8'd100});
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat);
      if (lat + 20 !== LAT) begin
         $display("FAIL ignored_start latency: got %0d want %0d", lat + 20, LAT); n_bad++;
      end
      n_cmp++;
      if ({bus.result, bus.ovf, bus.error} !== {er, eo, ee}) begin
         $display("FAIL ignored_start result: got r=%0d ovf=%b, want r=%0d ovf=%b",
                  bus.result, bus.ovf, er, eo); n_bad++;
      end
      n_cmp++;
      repeat (2) @(posedge clk);
      #1;
      if (bus.busy !== 1'b0) begin
         $display("FAIL ignored_start queued: got busy=%b want 0", bus.busy); n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_async_reset();
      op_t         op;
      logic [15:0] er;
      logic        eo, ee;
      int          lat;
      issue('{8'd9, 8'd8, 8'd7, 8'd6, 8'd1, 8'd4}, 1'b0);
      repeat (29) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      if ({bus.busy, bus.done, bus.result, bus.error, bus.ovf} !== 20'd0) begin
         $display("FAIL async_reset: got busy=%b done=%b r=%0d err=%b ovf=%b, want all 0",
                  bus.busy, bus.done, bus.result, bus.error, bus.ovf); n_bad++;
      end
      n_cmp++;
      @(negedge clk) rst = 1'b0;
      op = '{8'd2, 8'd0, 8'd3, 8'd0, 8'd4, 8'd10};
      model(op, er, eo, ee);
      issue(op, 1'b0);
      wait_done(lat);
      if ({lat, bus.result, bus.ovf, bus.error} !== {32'(LAT), er, eo, ee}) begin
         $display("FAIL after_reset: got lat=%0d r=%0d ovf=%b err=%b, want lat=%0d r=%0d ovf=%b err=%b",
                  lat, bus.result, bus.ovf, bus.error, LAT, er, eo, ee); n_bad++;
      end
      n_cmp++;
   endtask

   initial begin
      test_reset();
      test_plan_vectors();
      test_back_to_back();
      test_error_and_equal();
      test_overflow();
      test_random();
      test_ignored_start();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
